// File: rtl/pwm_capture.sv
// Servo PWM receiver: measures high time and rise-to-rise period, decodes a signed angle.
// Optional PWM_CAPTURE_GLITCH_FILTER_EN adds a GLITCH_CYCLES stability filter on the input.
module pwm_capture #(
  parameter int FREQ            = 25_000_000,
  parameter int TARGET_FREQ     = 10,
  parameter int MIN_DC          = 25_000,
  parameter int MAX_DC          = 125_000,
  parameter int COORD_MAX       = 270,
  parameter int BIT_SIZE        = 10,
  parameter int TIMEOUT_PERIODS = 2,
  parameter int GLITCH_CYCLES   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pwm_in,
  output logic [31:0]                high_count,
  output logic [31:0]                period_count,
  output logic signed [BIT_SIZE-1:0] angle,
  output logic                       valid,
  output logic                       range_err,
  output logic                       no_signal
);

  localparam logic [1:0] WAIT_RISE = 2'd0;
  localparam logic [1:0] HIGH      = 2'd1;
  localparam logic [1:0] LOW       = 2'd2;

  localparam logic [31:0] TO_CNT  = 32'(TIMEOUT_PERIODS * (FREQ / TARGET_FREQ));
  localparam longint      MID_DC  = (longint'(MIN_DC) + longint'(MAX_DC)) / 2;
  localparam longint      HALF_DC = (longint'(MAX_DC) - longint'(MIN_DC)) / 2;

  logic        s1, s2, lvl, prev;
  logic        rise, fall, tmo;
  logic [1:0]  state;
  logic [31:0] period_cnt, high_cnt;
  longint      hc, clamped, ang_full;
  logic        out_of_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic          filt;
  logic [GW-1:0] gcnt;

  // Level follows s2 only after GLITCH_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      gcnt <= '0;
    end else if (s2 == filt) begin
      gcnt <= '0;
    end else if (gcnt == GW'(GLITCH_CYCLES - 1)) begin
      filt <= s2;
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  logic unused_glitch;
  assign unused_glitch = ^GLITCH_CYCLES;
  assign lvl = s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= lvl;
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;
  assign tmo  = (period_cnt >= TO_CNT);

  always_comb begin
    hc           = longint'(high_cnt);
    clamped      = (hc < MIN_DC) ? longint'(MIN_DC) : (hc > MAX_DC) ? longint'(MAX_DC) : hc;
    ang_full     = ((clamped - MID_DC) * longint'(COORD_MAX)) / HALF_DC;
    out_of_range = (hc < MIN_DC) || (hc > MAX_DC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_RISE;
      period_cnt   <= '0;
      high_cnt     <= '0;
      high_count   <= '0;
      period_count <= '0;
      angle        <= '0;
      valid        <= 1'b0;
      range_err    <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT_RISE: begin
          if (rise) begin
            state      <= HIGH;
            period_cnt <= 32'd1;
            high_cnt   <= 32'd1;
          end
        end
        HIGH, LOW: begin
          // Timeout has priority over any edge seen in the same cycle.
          if (tmo) begin
            no_signal  <= 1'b1;
            state      <= WAIT_RISE;
            period_cnt <= '0;
            high_cnt   <= '0;
          end else if (state == HIGH) begin
            period_cnt <= period_cnt + 32'd1;
            if (fall) state    <= LOW;
            else      high_cnt <= high_cnt + 32'd1;
          end else if (rise) begin
            high_count   <= high_cnt;
            period_count <= period_cnt;
            angle        <= BIT_SIZE'(ang_full);
            range_err    <= out_of_range;
            valid        <= 1'b1;
            no_signal    <= 1'b0;
            period_cnt   <= 32'd1;
            high_cnt     <= 32'd1;
            state        <= HIGH;
          end else begin
            period_cnt <= period_cnt + 32'd1;
          end
        end
        default: begin
          state      <= WAIT_RISE;
          period_cnt <= '0;
          high_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
